// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one PC at a time, fetched over an AXI4-Lite read and
// held on a valid/ready port toward decode. Supports redirect flush and error tagging.
module ifu_fetch #(
    parameter int unsigned            ADDR_W   = 32,
    parameter int unsigned            DATA_W   = 32,
    parameter logic [DATA_W-1:0]      ERR_INST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              req_ready,
    input  logic              flush,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    input  logic              arready,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              rready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_inst,
    output logic              out_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic              r_drop;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_inst;
    logic              r_err;

    logic              w_misaligned;
    logic              w_discard;

    assign w_misaligned = (req_pc[1:0] != 2'b00);
    // A flush arriving together with the read data kills that data as well.
    assign w_discard    = r_drop | flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_pc <= req_pc;
                        if (w_misaligned) begin
                            r_err   <= 1'b1;
                            r_inst  <= ERR_INST;
                            r_state <= S_HOLD;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    // The address phase must still complete; only remember to drop the data.
                    if (flush) begin
                        r_drop <= 1'b1;
                    end
                    if (arready) begin
                        r_state <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        if (w_discard) begin
                            r_drop  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_inst  <= (rresp == 2'b00) ? rdata : ERR_INST;
                            r_err   <= (rresp != 2'b00);
                            r_state <= S_HOLD;
                        end
                    end else if (flush) begin
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (flush || out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign arvalid   = (r_state == S_AR);
    assign araddr    = r_pc;
    assign rready    = (r_state == S_R);
    assign out_valid = (r_state == S_HOLD) & ~flush;
    assign out_pc    = r_pc;
    assign out_inst  = r_inst;
    assign out_err   = r_err;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: stimulus pushes expected decode transactions,
// a negedge monitor pops and compares them and checks AR/HOLD stability.
module tb_ifu_fetch;

    localparam logic [31:0] ERR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        flush;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   hs_count = 0;

    ifu_fetch #(.ADDR_W(32), .DATA_W(32), .ERR_INST(ERR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .flush(flush),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // ---------------- monitor / scoreboard ----------------
    logic        ar_hold = 1'b0;
    logic [31:0] ar_snap;
    logic        out_hold = 1'b0;
    logic [31:0] snap_pc, snap_inst;
    logic        snap_err;

    always @(negedge clk) begin
        if (rst) begin
            ar_hold  = 1'b0;
            out_hold = 1'b0;
        end else begin
            if (ar_hold) begin
                n_cmp++;
                if (arvalid !== 1'b1 || araddr !== ar_snap) begin
                    n_err++;
                    $display("FAIL ar_stable: arvalid=%b araddr=%h required arvalid=1 araddr=%h", arvalid, araddr, ar_snap);
                end
            end
            ar_hold = arvalid && !arready;
            ar_snap = araddr;

            if (out_hold && !flush) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_pc !== snap_pc || out_inst !== snap_inst || out_err !== snap_err) begin
                    n_err++;
                    $display("FAIL hold_stable: valid=%b pc=%h inst=%h err=%b required valid=1 pc=%h inst=%h err=%b",
                             out_valid, out_pc, out_inst, out_err, snap_pc, snap_inst, snap_err);
                end
            end
            out_hold  = out_valid && !out_ready;
            snap_pc   = out_pc;
            snap_inst = out_inst;
            snap_err  = out_err;

            if (out_valid && out_ready) begin
                hs_count++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: pc=%h inst=%h err=%b required no transaction", out_pc, out_inst, out_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn pc=%h inst=%h err=%b (expected pc=%h inst=%h err=%b)",
                             out_pc, out_inst, out_err, e.pc, e.inst, e.err);
                    if (out_pc !== e.pc || out_inst !== e.inst || out_err !== e.err) begin
                        n_err++;
                        $display("FAIL out_txn: pc=%h inst=%h err=%b required pc=%h inst=%h err=%b",
                                 out_pc, out_inst, out_err, e.pc, e.inst, e.err);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic err);
        exp_t e;
        e.pc   = pc;
        e.inst = inst;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    task automatic accept(input logic [31:0] pc);
        req_valid = 1'b1;
        req_pc    = pc;
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Fetch with immediate arready and rvalid; optionally takes the result right away.
    task automatic fetch_fast(input logic [31:0] pc, input logic [31:0] data, input logic [1:0] resp,
                              input logic [31:0] exp_inst, input logic exp_err, input logic take);
        push_exp(pc, exp_inst, exp_err);
        accept(pc);
        check("arvalid_in_ar", {31'd0, arvalid}, 32'd1);
        check("araddr", araddr, pc);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rready_in_r", {31'd0, rready}, 32'd1);
        check("out_valid_not_early", {31'd0, out_valid}, 32'd0);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
        check("latency3_out_valid", {31'd0, out_valid}, 32'd1);
        if (take) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("idle_after_handshake", {31'd0, req_ready}, 32'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hs_before;
        rst = 1'b1; req_valid = 1'b0; req_pc = '0; flush = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check("rst_rready", {31'd0, rready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Basic fetch
        fetch_fast(32'h8000_0000, 32'h0010_0093, 2'b00, 32'h0010_0093, 1'b0, 1'b1);

        // Backpressure on every channel
        hs_before = hs_count;
        push_exp(32'h8000_0004, 32'h1234_5678, 1'b0);
        accept(32'h8000_0004);
        repeat (4) begin
            check("bp_araddr", araddr, 32'h8000_0004);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        repeat (3) begin
            check("bp_rready", {31'd0, rready}, 32'd1);
            tick();
        end
        rvalid = 1'b1; rdata = 32'h1234_5678;
        tick();
        rvalid = 1'b0;
        repeat (5) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (2) tick();
        check("bp_one_handshake", hs_count - hs_before, 32'd1);

        // Bus error response
        fetch_fast(32'h8000_0008, 32'hDEAD_BEEF, 2'b10, ERR, 1'b1, 1'b1);

        // Misaligned PC: no bus access, error after one cycle
        push_exp(32'h8000_0002, ERR, 1'b1);
        accept(32'h8000_0002);
        check("mis_arvalid", {31'd0, arvalid}, 32'd0);
        check("mis_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mis_arvalid_after", {31'd0, arvalid}, 32'd0);

        // Flush while in AR, bus completes later
        out_ready = 1'b1;
        accept(32'h8000_000C);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flar_arvalid_held", {31'd0, arvalid}, 32'd1);
        tick();
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'hAAAA_5555;
        tick();
        rvalid = 1'b0;
        check("flar_out_valid", {31'd0, out_valid}, 32'd0);
        check("flar_req_ready", {31'd0, req_ready}, 32'd1);

        // Flush coincident with rvalid
        accept(32'h8000_0018);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h5555_AAAA; flush = 1'b1;
        tick();
        rvalid = 1'b0; flush = 1'b0;
        check("flr_out_valid", {31'd0, out_valid}, 32'd0);
        check("flr_req_ready", {31'd0, req_ready}, 32'd1);
        out_ready = 1'b0;

        // Flush in HOLD together with out_ready
        fetch_fast(32'h8000_0014, 32'h0000_0013, 2'b00, 32'h0000_0013, 1'b0, 1'b0);
        tick();
        flush = 1'b1; out_ready = 1'b1;
        #1;
        check("flh_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        flush = 1'b0; out_ready = 1'b0;
        check("flh_idle", {31'd0, req_ready}, 32'd1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        fetch_fast(32'h8000_0010, 32'h00A0_0513, 2'b00, 32'h00A0_0513, 1'b0, 1'b1);

        // Flush in IDLE is ignored; request still accepted
        flush = 1'b1;
        push_exp(32'h8000_0040, 32'h0000_0073, 1'b0);
        accept(32'h8000_0040);
        flush = 1'b0;
        check("fli_arvalid", {31'd0, arvalid}, 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rdata = 32'h0000_0073;
        tick();
        rvalid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset while in R
        accept(32'h8000_0020);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("ar_rready_before", {31'd0, rready}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_arvalid", {31'd0, arvalid}, 32'd0);
        check("arst_rready", {31'd0, rready}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        rst = 1'b0;
        tick();
        fetch_fast(32'h8000_0024, 32'h0040_0113, 2'b00, 32'h0040_0113, 1'b0, 1'b1);

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
